// File: rtl/z3_to_z1_serializer.sv
// z3_to_z1_serializer: rate-transition serializer. Takes three slow-rate taps
// (newest, z^-1, z^-2) on the slow strobe and replays them at the fast rate,
// oldest tap first, with sticky underrun/overrun flags.
module z3_to_z1_serializer #(
    parameter int unsigned DATA_W = 11
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enb,
    input  logic                     enb_1_3_1,
    input  logic signed [DATA_W-1:0] In1,
    input  logic signed [DATA_W-1:0] In2,
    input  logic signed [DATA_W-1:0] In3,
    input  logic                     err_clr,
    output logic signed [DATA_W-1:0] Out1,
    output logic [1:0]               phase,
    output logic                     valid,
    output logic                     underrun,
    output logic                     overrun
);

    typedef enum logic [1:0] {
        PH_LOAD    = 2'd0,
        PH_EMIT1   = 2'd1,
        PH_EMIT2   = 2'd2,
        PH_ILLEGAL = 2'd3
    } phase_t;

    phase_t state_q, state_d;

    logic signed [DATA_W-1:0] b1_q, b2_q;
    logic signed [DATA_W-1:0] b1_d, b2_d, out_d;
    logic                     valid_d;
    logic                     under_set, over_set;
    logic                     do_load;

    // A strobe is honoured from any legal phase; a stray phase 3 just recovers.
    assign do_load = enb && enb_1_3_1 && (state_q != PH_ILLEGAL);
    assign phase   = state_q;

    // State register: phase advances only on enabled cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= PH_LOAD;
        else if (enb)
            state_q <= state_d;
    end

    // Next-state logic: strobe always resynchronises to the first emit slot.
    always_comb begin
        state_d = state_q;
        if (do_load) begin
            state_d = PH_EMIT1;
        end else begin
            case (state_q)
                PH_LOAD:  state_d = PH_LOAD;
                PH_EMIT1: state_d = PH_EMIT2;
                PH_EMIT2: state_d = PH_LOAD;
                default:  state_d = PH_LOAD;
            endcase
        end
    end

    // Output/datapath logic: next values for Out1, bank, valid and error events.
    always_comb begin
        out_d     = Out1;
        b1_d      = b1_q;
        b2_d      = b2_q;
        valid_d   = valid;
        under_set = 1'b0;
        over_set  = 1'b0;
        if (enb) begin
            if (do_load) begin
                b1_d    = In1;
                b2_d    = In2;
                out_d   = In3;
                valid_d = 1'b1;
                over_set = (state_q != PH_LOAD);
            end else begin
                case (state_q)
                    PH_LOAD: begin
                        valid_d   = 1'b0;
                        under_set = 1'b1;
                    end
                    PH_EMIT1: begin
                        out_d   = b2_q;
                        valid_d = 1'b1;
                    end
                    PH_EMIT2: begin
                        out_d   = b1_q;
                        valid_d = 1'b1;
                    end
                    default: valid_d = 1'b0;
                endcase
            end
        end
    end

    // Datapath registers: output sample, bank words and valid level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Out1  <= '0;
            b1_q  <= '0;
            b2_q  <= '0;
            valid <= 1'b0;
        end else if (enb) begin
            Out1  <= out_d;
            b1_q  <= b1_d;
            b2_q  <= b2_d;
            valid <= valid_d;
        end
    end

    // Sticky flags: err_clr works regardless of enb; a same-edge error wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underrun <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            underrun <= under_set | (underrun & ~err_clr);
            overrun  <= over_set  | (overrun  & ~err_clr);
        end
    end

endmodule

// File: doc/z3_to_z1_serializer.md
Name: z3_to_z1_serializer

Overview:
- Rate-transition serializer that converts three parallel slow-rate taps (newest, z^-1, z^-2) back into one fast-rate sample stream, oldest tap first.
- It is the inverse of the team's Z1toZ3 tapped-delay splitter.
- Sits at the output of the polyphase IIR section, after the slow-rate (1/3) arithmetic, and feeds the fast-rate output path.
- Uses the same clock-enable scheme as the splitter: enb is the fast enable; enb_1_3_1 is the slow-rate phase strobe.

Parameters:
- DATA_W, 11, sample width in bits; samples are signed fixed-point sfix11_En3 at the default. The block does no arithmetic, so the binary point only matters for interpretation.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- enb  in  1  fast-rate clock enable
- enb_1_3_1  in  1  slow-rate strobe: one fast-enable cycle in three; honoured only when enb=1
- In1  in  DATA_W  newest tap x[n], signed
- In2  in  DATA_W  tap x[n-1], signed
- In3  in  DATA_W  oldest tap x[n-2], signed
- err_clr  in  1  synchronous clear of the sticky error flags; not gated by enb
- Out1  out  DATA_W  serialized fast-rate sample, registered, signed
- phase  out  2  index of the next bank word to emit (0 = expecting load)
- valid  out  1  Out1 updated with a bank sample on this fast enable
- underrun  out  1  sticky flag
- overrun  out  1  sticky flag

Behaviour:
- Reset: the following clear to 0:
  - Out1, phase, valid, underrun, overrun
  - bank registers b1, b2 (DATA_W each)
- All state changes occur only on clk edges with enb=1, except err_clr and reset.
- Load (enb=1, enb_1_3_1=1, phase=0):
  - b2<=In2, b1<=In1
  - Out1<=In3, valid<=1, phase<=1
  - Latency is one clk from the strobe to the oldest tap appearing on Out1.
- Emit 1 (enb=1, strobe=0, phase=1): Out1<=b2, valid<=1, phase<=2.
- Emit 2 (enb=1, strobe=0, phase=2): Out1<=b1, valid<=1, phase<=0.
- Serial order per slow frame is therefore In3, In2, In1, i.e. x[n-2], x[n-1], x[n], matching the time order.
- Underrun (enb=1, strobe=0, phase=0):
  - Out1 holds its previous value, valid<=0, phase stays 0
  - underrun<=1
- Overrun (enb=1, strobe=1, phase≠0):
  - The unsent bank word(s) are dropped.
  - A normal load is performed: b2/b1 reload, Out1<=In3, phase<=1, valid<=1.
  - overrun<=1
  - This resynchronises the block to the strobe.
- enb=0: all state holds, including valid; strobe is ignored.
- valid is a registered level that changes only on enb edges; a consumer samples it together with Out1 on the next enb.
- err_clr=1 on a clk edge clears underrun and overrun. If a new error is detected on the same edge, the error set wins.
- reset asserted mid-frame: immediate clear; the next load requires phase=0, so the first strobe after reset release is a normal load with no error flag.
- Data is passed bit-exact; no rounding, saturation or sign handling beyond passing DATA_W bits unchanged.
- phase never takes the value 3. If it is ever found at 3, it returns to 0 on the next enb; no flag is raised.

Test Plan:
- Reset then steady stream: enb=1 every cycle, strobe every 3rd cycle starting cycle 0.
  - Frame 1 In1=24, In2=16, In3=8; frame 2 In1=-8, In2=-16, In3=-24.
  - Required Out1 sequence from cycle 1: 8, 16, 24, -24, -16, -8.
  - valid=1 throughout; phase 1,2,0 repeating; no flags.
- Enable gating: enb=1 every 2nd clk, strobe on every 3rd enabled cycle, same data as above.
  - Out1 shows the same 6-value sequence; each value holds across the intervening enb=0 cycle.
  - phase advances only on enabled cycles.
- Underrun: after a frame with In3..In1=5,6,7, withhold the strobe for 2 extra enabled cycles.
  - Out1 holds 7; valid=0 on both cycles; underrun=1 and stays set.
  - The next strobe loads normally.
- Overrun: strobe at phase=1 with new In3=100, In2=101, In1=102.
  - Out1=100 on the next cycle, then 101, 102.
  - The old b2/b1 values never appear; overrun=1.
- err_clr: with both flags set, pulse err_clr for one cycle → both flags 0.
  - Pulse err_clr on the same edge as an underrun → underrun=1, overrun=0.
- Async reset mid-frame at phase=2 with Out1=-1024 (extreme value, verifies sign pass-through on the preceding load).
  - Reset → Out1=0, phase=0, valid=0, flags 0 immediately, without waiting for a clk edge.
  - First strobe after release is a normal load with no flag.
